// File: rtl/lfsr_seq.sv
// rtl/lfsr_seq.sv - seeded XNOR Fibonacci LFSR sequencer with wrap/one-shot control
// Define LFSR_PERIOD_CNT_EN to include the period counter and period_out.
module lfsr_seq #(
  parameter int          NUM_BITS = 8,
  parameter int          STEP     = 1,
  parameter logic [31:0] TAPS     = 32'd0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                seed_valid,
  input  logic [NUM_BITS-1:0] seed_data,
  output logic                seed_ready,
  input  logic                mode,
  input  logic                stop,
  output logic [NUM_BITS-1:0] lfsr_data,
  output logic                lfsr_wrap,
  output logic                lfsr_done,
  output logic                seed_err,
  output logic                lockup_err,
  output logic [NUM_BITS-1:0] period_out
);

  // Maximal-length XNOR taps, bit k set = tap on register bit k (0-based).
  function automatic logic [31:0] builtin_taps(input int n);
    case (n)
      3:  return 32'h0000_0006;
      4:  return 32'h0000_000C;
      5:  return 32'h0000_0014;
      6:  return 32'h0000_0030;
      7:  return 32'h0000_0060;
      8:  return 32'h0000_00B8;
      9:  return 32'h0000_0110;
      10: return 32'h0000_0240;
      11: return 32'h0000_0500;
      12: return 32'h0000_0829;
      13: return 32'h0000_100D;
      14: return 32'h0000_2015;
      15: return 32'h0000_6000;
      16: return 32'h0000_D008;
      17: return 32'h0001_2000;
      18: return 32'h0002_0400;
      19: return 32'h0004_0023;
      20: return 32'h0009_0000;
      21: return 32'h0014_0000;
      22: return 32'h0030_0000;
      23: return 32'h0042_0000;
      24: return 32'h00E1_0000;
      25: return 32'h0120_0000;
      26: return 32'h0200_0023;
      27: return 32'h0400_0013;
      28: return 32'h0900_0000;
      29: return 32'h1400_0000;
      30: return 32'h2000_0029;
      31: return 32'h4800_0000;
      32: return 32'h8020_0003;
      default: return 32'h0000_0000;
    endcase
  endfunction

  localparam logic [31:0]         TAP_ALL  = (TAPS != 32'd0) ? TAPS : builtin_taps(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK = TAP_ALL[NUM_BITS-1:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] lfsr_q, seed_q, adv;
  logic                mode_q;
  logic                seed_fire, seed_bad, load_seed;
  logic                step_en, lock_hit, wrap_hit;

  always_comb begin
    adv = lfsr_q;
    for (int i = 0; i < STEP; i++) begin
      adv = {adv[NUM_BITS-2:0], ~^(adv & TAP_MASK)};
    end
  end

  assign seed_ready = (state_q == IDLE) || (state_q == DONE);
  assign seed_fire  = seed_valid && seed_ready;
  assign seed_bad   = (seed_data == '1);
  assign load_seed  = seed_fire && !seed_bad;
  assign step_en    = (state_q == RUN) && !stop && enable;
  assign lock_hit   = step_en && (adv == '1);
  assign wrap_hit   = step_en && !lock_hit && (adv == seed_q);

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (load_seed) state_d = RUN;
      RUN: begin
        if (stop)                    state_d = IDLE;
        else if (wrap_hit && mode_q) state_d = DONE;
      end
      DONE: begin
        // A seed offer in the same cycle as stop takes precedence.
        if (load_seed)                state_d = RUN;
        else if (stop && !seed_fire)  state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q     <= '0;
      seed_q     <= '0;
      mode_q     <= 1'b0;
      lfsr_wrap  <= 1'b0;
      seed_err   <= 1'b0;
      lockup_err <= 1'b0;
    end else begin
      lfsr_wrap  <= wrap_hit;
      seed_err   <= seed_fire && seed_bad;
      lockup_err <= lock_hit;
      if (load_seed) begin
        lfsr_q <= seed_data;
        seed_q <= seed_data;
        mode_q <= mode;
      end else if (lock_hit) begin
        lfsr_q <= seed_q;
      end else if (step_en) begin
        lfsr_q <= adv;
      end
    end
  end

  assign lfsr_data = lfsr_q;
  assign lfsr_done = (state_q == DONE);

`ifdef LFSR_PERIOD_CNT_EN
  logic [NUM_BITS-1:0] cnt_q, period_q, cnt_next;

  assign cnt_next = (cnt_q == '1) ? cnt_q : cnt_q + {{(NUM_BITS-1){1'b0}}, 1'b1};

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      period_q <= '0;
    end else if (load_seed || lock_hit) begin
      cnt_q <= '0;
    end else if (wrap_hit) begin
      period_q <= cnt_next;
      cnt_q    <= '0;
    end else if (step_en) begin
      cnt_q <= cnt_next;
    end
  end

  assign period_out = period_q;
`else
  assign period_out = '0;
`endif

endmodule

// File: tb/tb_lfsr_seq.sv
// tb/tb_lfsr_seq.sv - checks two 5-bit lfsr_seq instances (STEP 1 and 2) against a reference model
module tb_lfsr_seq;

  logic       clk;
  logic       reset_n;
  logic       enable;
  logic       seed_valid;
  logic [4:0] seed_data;
  logic       mode;
  logic       stop;

  logic       ready_o [2];
  logic [4:0] data_o  [2];
  logic       wrap_o  [2];
  logic       done_o  [2];
  logic       serr_o  [2];
  logic       lerr_o  [2];
  logic [4:0] per_o   [2];

  int n_assert = 0;
  int n_fail   = 0;

  int m_state [2];
  int m_reg   [2];
  int m_seed  [2];
  int m_mode  [2];
  int m_cnt   [2];
  int m_per   [2];
  bit e_wrap  [2];
  bit e_serr  [2];

  lfsr_seq #(.NUM_BITS(5), .STEP(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_ready(ready_o[0]), .mode(mode), .stop(stop),
    .lfsr_data(data_o[0]), .lfsr_wrap(wrap_o[0]), .lfsr_done(done_o[0]),
    .seed_err(serr_o[0]), .lockup_err(lerr_o[0]), .period_out(per_o[0])
  );

  lfsr_seq #(.NUM_BITS(5), .STEP(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable), .seed_valid(seed_valid),
    .seed_data(seed_data), .seed_ready(ready_o[1]), .mode(mode), .stop(stop),
    .lfsr_data(data_o[1]), .lfsr_wrap(wrap_o[1]), .lfsr_done(done_o[1]),
    .seed_err(serr_o[1]), .lockup_err(lerr_o[1]), .period_out(per_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Taps at 1-based bits 5 and 3; feedback bit is their XNOR.
  function automatic int shift_n(input int r, input int n);
    int fb;
    for (int i = 0; i < n; i++) begin
      fb = (((r >> 4) ^ (r >> 2)) & 1) ^ 1;
      r  = ((r << 1) | fb) & 31;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit v, input int d, input bit md, input bit en,
                              input bit st, input bit rn);
    int nx;
    int c;
    for (int k = 0; k < 2; k++) begin
      e_wrap[k] = 1'b0;
      e_serr[k] = 1'b0;
      if (!rn) begin
        m_state[k] = 0; m_reg[k] = 0; m_seed[k] = 0;
        m_mode[k]  = 0; m_cnt[k] = 0; m_per[k]  = 0;
      end else if (m_state[k] != 1 && v) begin
        if (d == 31) e_serr[k] = 1'b1;
        else begin
          m_reg[k] = d; m_seed[k] = d; m_mode[k] = md; m_cnt[k] = 0; m_state[k] = 1;
        end
      end else if (m_state[k] != 0 && st) begin
        m_state[k] = 0;
      end else if (m_state[k] == 1 && en) begin
        nx = shift_n(m_reg[k], k + 1);
        c  = (m_cnt[k] + 1 > 31) ? 31 : m_cnt[k] + 1;
        m_reg[k] = nx;
        if (nx == m_seed[k]) begin
          e_wrap[k] = 1'b1;
          m_per[k]  = c;
          m_cnt[k]  = 0;
          if (m_mode[k] != 0) m_state[k] = 2;
        end else begin
          m_cnt[k] = c;
        end
      end
    end
  endtask

  task automatic check_all();
    int exp_per;
    for (int k = 0; k < 2; k++) begin
`ifdef LFSR_PERIOD_CNT_EN
      exp_per = m_per[k];
`else
      exp_per = 0;
`endif
      chk($sformatf("data%0d", k),  32'(data_o[k]),  32'(m_reg[k]));
      chk($sformatf("ready%0d", k), 32'(ready_o[k]), 32'(m_state[k] != 1));
      chk($sformatf("done%0d", k),  32'(done_o[k]),  32'(m_state[k] == 2));
      chk($sformatf("wrap%0d", k),  32'(wrap_o[k]),  32'(e_wrap[k]));
      chk($sformatf("serr%0d", k),  32'(serr_o[k]),  32'(e_serr[k]));
      chk($sformatf("lerr%0d", k),  32'(lerr_o[k]),  32'd0);
      chk($sformatf("period%0d", k), 32'(per_o[k]),  32'(exp_per));
    end
  endtask

  task automatic step(input bit v, input int d, input bit md, input bit en,
                      input bit st, input bit rn);
    seed_valid = v; seed_data = 5'(d); mode = md; enable = en; stop = st; reset_n = rn;
    @(posedge clk);
    model_update(v, d, md, en, st, rn);
    #1;
    check_all();
  endtask

  initial begin
    int n;
    int s;
    int s2;
    int exp_seq [4];
    exp_seq[0] = 1; exp_seq[1] = 3; exp_seq[2] = 7; exp_seq[3] = 14;
    seed_valid = 0; seed_data = 0; mode = 0; enable = 0; stop = 0; reset_n = 0;

    repeat (3) step(0, 0, 0, 0, 0, 0);
    chk("reset_ready", 32'(ready_o[0]), 32'd1);
    chk("reset_data",  32'(data_o[0]),  32'd0);

    // Seed 0, free-run; enable is ignored in the transfer cycle.
    step(1, 0, 0, 1, 0, 1);
    chk("load_data", 32'(data_o[0]), 32'd0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, 1);
      chk($sformatf("seq_step1_%0d", i), 32'(data_o[0]), 32'(exp_seq[i]));
      if (i == 0) chk("seq_step2_0", 32'(data_o[1]), 32'd3);
      if (i == 1) chk("seq_step2_1", 32'(data_o[1]), 32'd14);
    end

    n = 0;
    while (!wrap_o[0] && n < 100) begin
      step(0, 0, 0, 1, 0, 1);
      n++;
    end
    chk("wrap_cycles", 32'(4 + n), 32'd31);
    chk("wrap_still_run", 32'(ready_o[0]), 32'd0);

    repeat (200) step(0, 0, 0, 1'($urandom), 0, 1);
    step(0, 0, 0, 1, 1, 1);
    chk("stop_idle", 32'(ready_o[0]), 32'd1);

    step(1, 31, 0, 1, 0, 1);
    chk("bad_seed_err", 32'(serr_o[0]), 32'd1);
    chk("bad_seed_ready", 32'(ready_o[0]), 32'd1);
    step(0, 0, 0, 1, 0, 1);

    s = $urandom_range(0, 30);
    step(1, s, 1, 0, 0, 1);
    n = 0;
    while (!done_o[0] && n < 400) begin
      step(0, 0, 1, 1'($urandom), 0, 1);
      n++;
    end
    chk("oneshot_done", 32'(done_o[0]), 32'd1);
    repeat (3) step(0, 0, 0, 1, 0, 1);
    chk("oneshot_frozen", 32'(data_o[0]), 32'(s));
    chk("oneshot_ready", 32'(ready_o[0]), 32'd1);
    step(0, 0, 0, 1, 1, 1);
    chk("done_stop", 32'(done_o[0]), 32'd0);

    step(1, s, 1, 0, 0, 1);
    repeat (70) step(0, 0, 1, 1, 0, 1);
    s2 = $urandom_range(0, 30);
    step(1, s2, 0, 1, 1, 1);
    chk("stop_vs_seed", 32'(data_o[0]), 32'(s2));
    chk("stop_vs_seed_run", 32'(ready_o[0]), 32'd0);

    repeat (10) step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, 0, 0);
    chk("rst_mid_data", 32'(data_o[0]), 32'd0);
    chk("rst_mid_ready", 32'(ready_o[0]), 32'd1);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) == 0), $urandom_range(0, 31), 1'($urandom),
           ($urandom_range(0, 3) != 0), ($urandom_range(0, 29) == 0),
           ($urandom_range(0, 199) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
